// File: rtl/muldiv_ctrl.sv
// HI/LO owner and multi-cycle sequencer for mult/multu/div/divu.
// Iterative shift-add multiply / restoring divide on magnitudes, sign fix-up in FIX.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_val,
  input  logic             hilo_rd,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, is_signed_q, is_signed_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic               done_q, done_d, div_zero_q, div_zero_d;

  // Magnitudes of the operands; unsigned ops pass straight through.
  logic             op_signed;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  assign op_signed = ~op[0];
  assign rs_abs = (op_signed && rs_val[WIDTH-1]) ? ('0 - rs_val) : rs_val;
  assign rt_abs = (op_signed && rt_val[WIDTH-1]) ? ('0 - rt_val) : rt_val;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_mul;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
  assign acc_mul = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc = {remainder, dividend bits shifting out / quotient bits in}.
  logic [WIDTH:0]     div_trial, div_diff;
  logic [2*WIDTH-1:0] acc_div;
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, b_q};
  assign acc_div   = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quot_neg, rem_neg;
  assign prod_neg = '0 - acc_q;
  assign quot_neg = '0 - acc_q[WIDTH-1:0];
  assign rem_neg  = '0 - acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    done_d      = 1'b0;
    div_zero_d  = div_zero_q;
    case (state_q)
      IDLE: begin
        if (mthi) hi_d = wr_val;
        if (mtlo) lo_d = wr_val;
        if (start) begin
          count_d    = '0;
          div_zero_d = 1'b0;
          if (op[1] && (rt_val == '0)) begin
            div_zero_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            is_div_d    = op[1];
            is_signed_d = op_signed;
            sign_a_d    = rs_val[WIDTH-1];
            sign_b_d    = rt_val[WIDTH-1];
            b_d         = op[1] ? rt_abs : rs_abs;
            acc_d       = {{WIDTH{1'b0}}, (op[1] ? rs_abs : rt_abs)};
            state_d     = CALC;
          end
        end
      end
      CALC: begin
        acc_d   = is_div_q ? acc_div : acc_mul;
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = (is_signed_q && (sign_a_q ^ sign_b_q)) ? quot_neg : acc_q[WIDTH-1:0];
          hi_d = (is_signed_q && sign_a_q) ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
        end else if (is_signed_q && (sign_a_q ^ sign_b_q)) begin
          {hi_d, lo_d} = prod_neg;
        end else begin
          {hi_d, lo_d} = acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign stall    = (hilo_rd | mthi | mtlo | start) & busy;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
